// File: rtl/prf_timing_gen.sv
// prf_timing_gen: radar pulse-timing generator.
//   Produces the PRI start marker (prf), the delayed transmit trigger (tr) and
//   a calibration window (ct) that lasts one full PRI. prf and tr also have
//   one-cycle rise/fall flags. New count settings are taken on an update
//   strobe. While running they are held in a pending buffer and only become
//   active at the next PRI wrap, so a PRI is never altered part-way through.
// Optional feature macro: PRF_TIMING_CT_EN
//   When it is defined, the calibration interval timer and the ct logic are
//   built. When it is not defined, ct is tied to 0 and ct_clock_num is ignored.
// Ports:
//   clk, rst (async, active low)
//   update                                      - strobe that takes new settings
//   pulse_clock_num / sweep_clock_num /
//   ys_clock_num / ct_clock_num                 - count settings in clocks
//   prf, prf_edge[1:0], tr, tr_edge[1:0], ct    - registered outputs;
//                                                 edge bit [0] = rise, [1] = fall
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | stopped: outputs driven to 0, pc held at 0
// ST_RUN  | pc walks 0..s_period-1; outputs follow the pc being emitted
module prf_timing_gen #(
  parameter int unsigned CNT_W          = 32,
  parameter bit          START_ON_RESET = 1'b0,
  parameter int unsigned DEF_PERIOD     = 1000,
  parameter int unsigned DEF_PULSE      = 100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             update,
  input  logic [CNT_W-1:0] pulse_clock_num,
  input  logic [CNT_W-1:0] sweep_clock_num,
  input  logic [CNT_W-1:0] ys_clock_num,
  input  logic [CNT_W-1:0] ct_clock_num,
  output logic             tr,
  output logic [1:0]       tr_edge,
  output logic             prf,
  output logic [1:0]       prf_edge,
  output logic             ct
);

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
  localparam logic [CNT_W-1:0] RST_PERIOD = START_ON_RESET ? CNT_W'(DEF_PERIOD) : '0;
  localparam logic [CNT_W-1:0] RST_PULSE  = START_ON_RESET ? CNT_W'(DEF_PULSE) : '0;
  localparam state_t           RST_STATE  = START_ON_RESET ? ST_RUN : ST_IDLE;

  state_t           state;
  logic [CNT_W-1:0] pc;
  logic [CNT_W-1:0] s_pulse, s_period, s_ys;
  logic [CNT_W-1:0] p_pulse, p_period, p_ys;
  logic             upd_pend;

  logic             prf_nxt, tr_nxt, pc_last, apply_now, start_now;
  logic [CNT_W:0]   tr_end;
  logic [CNT_W-1:0] src_pulse, src_period, src_ys;

  // pc is the phase that will be emitted at the next clock edge.
  always_comb begin
    prf_nxt    = (pc < s_pulse);
    // Computed one bit wider so that a large ys + pulse clips at the PRI end
    // instead of wrapping around.
    tr_end     = {1'b0, s_ys} + {1'b0, s_pulse};
    tr_nxt     = (pc >= s_ys) && ({1'b0, pc} < tr_end) && (pc < s_period);
    pc_last    = (pc == s_period - ONE);
    start_now  = (state == ST_IDLE) && update && (sweep_clock_num != '0);
    apply_now  = (state == ST_RUN) && pc_last && (update || upd_pend);
    // An update that coincides with the wrap takes priority over the pending buffer.
    src_pulse  = update ? pulse_clock_num : p_pulse;
    src_period = update ? sweep_clock_num : p_period;
    src_ys     = update ? ys_clock_num    : p_ys;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= RST_STATE;
      pc       <= '0;
      s_pulse  <= RST_PULSE;
      s_period <= RST_PERIOD;
      s_ys     <= '0;
      p_pulse  <= '0;
      p_period <= '0;
      p_ys     <= '0;
      upd_pend <= 1'b0;
      prf      <= 1'b0;
      tr       <= 1'b0;
      prf_edge <= 2'b00;
      tr_edge  <= 2'b00;
    end else begin
      case (state)
        ST_IDLE: begin
          prf      <= 1'b0;
          tr       <= 1'b0;
          prf_edge <= {prf, 1'b0};
          tr_edge  <= {tr, 1'b0};
          pc       <= '0;
          upd_pend <= 1'b0;
          if (start_now) begin
            s_pulse  <= pulse_clock_num;
            s_period <= sweep_clock_num;
            s_ys     <= ys_clock_num;
            state    <= ST_RUN;
          end
        end
        ST_RUN: begin
          prf      <= prf_nxt;
          tr       <= tr_nxt;
          prf_edge <= {prf & ~prf_nxt, ~prf & prf_nxt};
          tr_edge  <= {tr & ~tr_nxt, ~tr & tr_nxt};
          if (pc_last) begin
            pc <= '0;
            if (apply_now) begin
              s_pulse  <= src_pulse;
              s_period <= src_period;
              s_ys     <= src_ys;
              upd_pend <= 1'b0;
              if (src_period == '0) state <= ST_IDLE;
            end
          end else begin
            pc <= pc + ONE;
            if (update) begin
              p_pulse  <= pulse_clock_num;
              p_period <= sweep_clock_num;
              p_ys     <= ys_clock_num;
              upd_pend <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef PRF_TIMING_CT_EN
  logic [CNT_W-1:0] s_ct, p_ct, ic, src_ct;
  logic             ct_pend, ct_expire;

  assign src_ct    = update ? ct_clock_num : p_ct;
  // ic is a down-counter. It expires on the S_ct-th run clock after it is loaded.
  assign ct_expire = (s_ct != '0) && (ic == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_ct    <= '0;
      p_ct    <= '0;
      ic      <= '0;
      ct_pend <= 1'b0;
      ct      <= 1'b0;
    end else if (state == ST_IDLE) begin
      ct      <= 1'b0;
      ct_pend <= 1'b0;
      ic      <= (start_now && ct_clock_num != '0) ? ct_clock_num - ONE : '0;
      if (start_now) s_ct <= ct_clock_num;
    end else begin
      // pc == 0 means that this edge emits the first clock of a PRI.
      if (pc == '0) begin
        ct      <= ct_pend;
        ct_pend <= ct_expire;
      end else if (ct_expire) begin
        ct_pend <= 1'b1;
      end
      if (s_ct == '0)   ic <= '0;
      else if (ct_expire) ic <= s_ct - ONE;
      else              ic <= ic - ONE;
      if (apply_now) begin
        s_ct    <= src_ct;
        ic      <= (src_ct != '0) ? src_ct - ONE : '0;
        ct_pend <= 1'b0;
      end else if (update && !pc_last) begin
        p_ct <= ct_clock_num;
      end
    end
  end
`else
  logic ct_unused;
  assign ct_unused = ^ct_clock_num;
  assign ct        = 1'b0;
`endif

endmodule
